data_ram_ctrl: RTL and testbench
================================

Name: data_ram_ctrl

Overview:
- Data-memory responder for the 8-bit datapath.
- Accepts load (LDA/LDB) and store requests from control and services them with configurable wait states.
- Produces ram_data_out, which the register write-back select path consumes, plus a ready/busy handshake for stalling the core.
- Holds the data RAM array internally.

Parameters:
ADDR_W, 8, address width in bits
DEPTH, 256, number of 8-bit words implemented (1..2^ADDR_W)
READ_LAT, 2, cycles from request acceptance to read-data valid (>=1)
WRITE_LAT, 1, cycles from request acceptance to write commit (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
mem_req  input  1  request strobe, sampled only in IDLE
MemRead  input  1  request is a load
MemWrite  input  1  request is a store
addr  input  ADDR_W  word address
wr_data  input  8  store data
ram_data_out  output  8  last completed load data
mem_ready  output  1  one-cycle pulse at completion of any accepted request
busy  output  1  high from the cycle after acceptance through the completion cycle
mem_err  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset: synchronous, active-low; takes effect on the clk edge while rst_n=0.
  - State -> IDLE.
  - ram_data_out=0, mem_ready=0, busy=0, mem_err=0, latency counter=0.
  - RAM array contents are not cleared.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - mem_req=1 and MemRead=1, MemWrite=0: latch addr, load counter=READ_LAT-1, go to RD_WAIT.
  - mem_req=1 and MemWrite=1, MemRead=0: latch addr and wr_data, load counter=WRITE_LAT-1, go to WR_WAIT.
  - mem_req=1 with MemRead=MemWrite=1 or MemRead=MemWrite=0: not accepted; pulse mem_err next cycle; stay in IDLE.
  - mem_req=0: stay in IDLE, outputs quiet.
- RD_WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0: ram_data_out <= mem[latched addr], mem_ready=1 for that cycle, then go to DONE.
  - Read latency is exactly READ_LAT cycles: request sampled at edge N, mem_ready high in the cycle following edge N+READ_LAT.
- WR_WAIT:
  - Same counting as RD_WAIT.
  - When the counter is 0: mem[latched addr] <= latched wr_data, mem_ready=1, go to DONE.
  - ram_data_out is unchanged by stores.
- DONE:
  - One recovery cycle: busy=0, mem_ready=0, new requests ignored; always return to IDLE.
  - Back-to-back requests are therefore separated by at least one idle cycle.
- busy:
  - High in RD_WAIT and WR_WAIT, including the completion cycle.
  - Low in IDLE and DONE.
- Request inputs (mem_req, MemRead, MemWrite, addr, wr_data) are ignored outside IDLE; latched values are used throughout.
- ram_data_out holds its value until the next load completes.
- Address handling: only addr modulo DEPTH indexes the array, unless the optional feature is enabled.
- Reset mid-operation: transaction aborted; a store not yet committed is never written; no mem_ready pulse.
- Read-after-write to the same address returns the new data, because commit precedes the next acceptance.

Optional Feature:
- Macro: DATA_RAM_BOUNDS_CHECK_EN.
- Defined:
  - An otherwise valid request with addr >= DEPTH is not accepted.
  - mem_err pulses one cycle later; state stays IDLE; RAM and ram_data_out are untouched; no mem_ready.
- Undefined:
  - No range check; the address wraps modulo DEPTH.
  - mem_err is asserted only for illegal MemRead/MemWrite combinations.

Test Plan:
- Reset, then store: with WRITE_LAT=1, store 0x5A to addr 0x10 -> busy for 1 cycle, mem_ready pulse, then a load of 0x10 with READ_LAT=2 -> mem_ready 2 cycles after acceptance, ram_data_out=0x5A.
- Latency sweep: READ_LAT=1 and READ_LAT=4 loads of a pre-stored 0xC3 -> mem_ready exactly 1 and 4 cycles after acceptance; busy high for the same count; ram_data_out=0xC3.
- Illegal request: MemRead=MemWrite=1 with mem_req -> mem_err pulse, no busy, no mem_ready, RAM unchanged; MemRead=MemWrite=0 with mem_req -> same result.
- Busy ignore: during RD_WAIT, drive a store of 0xFF to the same address -> the store is not performed; a later load still returns the old value.
- Reset mid-store: with WRITE_LAT=3, drop rst_n during WR_WAIT -> no commit, outputs 0, IDLE; a later load returns the prior contents.
- Bounds (DEPTH=128, macro defined): load of addr 0x80 -> mem_err pulse, ram_data_out unchanged. With the macro undefined: the same load returns mem[0x00].

Source files
------------

// File: rtl/data_ram_ctrl.sv
// Data-memory responder: services load/store requests against an internal
// 8-bit RAM with fixed READ_LAT/WRITE_LAT wait states.
// Optional macro DATA_RAM_BOUNDS_CHECK_EN rejects addresses >= DEPTH instead of wrapping.
module data_ram_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        ram_data_out,
  output logic              mem_ready,
  output logic              busy,
  output logic              mem_err,
  output logic [1:0]        state_dbg
);

  // Handshake: mem_req is sampled only while idle. An accepted request raises
  // busy from the next cycle for exactly its latency, then mem_ready pulses for
  // one cycle (the recovery cycle); a rejected request pulses mem_err instead.
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        wr_q;
  logic [7:0]        mem [DEPTH];

  logic [31:0]       addr_ext;
  logic [IDX_W-1:0]  idx;
  logic              range_ok;
  logic              rd_ok;
  logic              wr_ok;
  logic              commit;

  assign addr_ext = 32'(addr);
  assign idx      = IDX_W'(addr_ext % 32'(DEPTH));

`ifdef DATA_RAM_BOUNDS_CHECK_EN
  assign range_ok = (addr_ext < 32'(DEPTH));
`else
  assign range_ok = 1'b1;
`endif

  assign rd_ok  = MemRead  & ~MemWrite & range_ok;
  assign wr_ok  = MemWrite & ~MemRead  & range_ok;
  // Gated by rst_n so a store caught by reset on its final cycle never lands.
  assign commit = rst_n && (state == WR_WAIT) && (cnt == '0);

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx_q] <= wr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ram_data_out <= 8'h00;
      mem_ready    <= 1'b0;
      busy         <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            if (rd_ok) begin
              idx_q <= idx;
              cnt   <= CNT_W'(READ_LAT - 1);
              busy  <= 1'b1;
              state <= RD_WAIT;
            end else if (wr_ok) begin
              idx_q <= idx;
              wr_q  <= wr_data;
              cnt   <= CNT_W'(WRITE_LAT - 1);
              busy  <= 1'b1;
              state <= WR_WAIT;
            end else begin
              mem_err <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            ram_data_out <= mem[idx_q];
            mem_ready    <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            mem_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: vector table, hand-written corner sequences and a
// randomized run checked against an array-based model of the memory.
module tb_data_ram_ctrl;

  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 128;
  localparam int READ_LAT  = 4;
  localparam int WRITE_LAT = 3;
  localparam int MAX_LAT   = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int WIN       = MAX_LAT + 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_req;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wr_data;
  logic [7:0]        ram_data_out;
  logic              mem_ready;
  logic              busy;
  logic              mem_err;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  data_ram_ctrl #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .MemRead(MemRead),
    .MemWrite(MemWrite), .addr(addr), .wr_data(wr_data),
    .ram_data_out(ram_data_out), .mem_ready(mem_ready), .busy(busy),
    .mem_err(mem_err), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic [7:0] model_mem [DEPTH];
  bit         model_vld [DEPTH];
  logic [7:0] model_rd;

  typedef struct {
    bit         req;
    bit         rd;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    bit         exp_acc;
    bit         exp_err;
    logic [7:0] exp_rdo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model from the request rules: legality, range, wrap modulo DEPTH.
  function automatic void model_eval(input bit req, input bit rd, input bit wr,
                                     input logic [7:0] a, input logic [7:0] d,
                                     output bit acc, output bit err,
                                     output logic [7:0] rdo);
    int  i;
    bit  inr;
    i = int'(a) % DEPTH;
`ifdef DATA_RAM_BOUNDS_CHECK_EN
    inr = (int'(a) < DEPTH);
`else
    inr = 1'b1;
`endif
    acc = req && (rd != wr) && inr;
    err = req && !acc;
    if (acc && wr) begin
      model_mem[i] = d;
      model_vld[i] = 1'b1;
    end
    if (acc && rd) model_rd = model_mem[i];
    rdo = model_rd;
  endfunction

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic run_req(input string tag, input bit req, input bit rd, input bit wr,
                         input logic [7:0] a, input logic [7:0] d,
                         input bit exp_acc, input bit exp_err,
                         input logic [7:0] exp_rdo, input bit junk);
    int lat, busy_n, rdy_n, rdy_pos, err_n, err_pos;
    lat = rd ? READ_LAT : WRITE_LAT;
    busy_n = 0; rdy_n = 0; rdy_pos = 0; err_n = 0; err_pos = 0;
    if (exp_acc && rd) exp_q.push_back(exp_rdo);
    mem_req = req; MemRead = rd; MemWrite = wr; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    if (junk) begin
      mem_req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; wr_data = 8'hFF;
    end else begin
      mem_req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    end
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (mem_err) begin err_n++; err_pos = k; end
      if (mem_ready) begin
        rdy_n++;
        rdy_pos = k;
        if (exp_q.size() > 0) check({tag, "_ready_data"}, ram_data_out, exp_q.pop_front());
      end
      if (k == lat + 1) begin
        mem_req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      end
    end
    if (exp_acc) begin
      check({tag, "_busy_cycles"}, busy_n, lat);
      check({tag, "_ready_pos"}, rdy_pos, lat + 1);
      check({tag, "_ready_cnt"}, rdy_n, 1);
    end else begin
      check({tag, "_busy_cycles"}, busy_n, 0);
      check({tag, "_ready_cnt"}, rdy_n, 0);
    end
    check({tag, "_err_cnt"}, err_n, exp_err ? 1 : 0);
    if (exp_err) check({tag, "_err_pos"}, err_pos, 1);
    check({tag, "_rdata"}, ram_data_out, exp_rdo);
  endtask

  task automatic add_vec(input bit req, input bit rd, input bit wr, input logic [7:0] a,
                         input logic [7:0] d, input bit acc, input bit err,
                         input logic [7:0] rdo);
    vec_t v;
    v.req = req; v.rd = rd; v.wr = wr; v.a = a; v.d = d;
    v.exp_acc = acc; v.exp_err = err; v.exp_rdo = rdo;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         acc, err, junk;
    logic [7:0] rdo, a, d;
    int         op, rdy_n;

    model_rd = 8'h00;
    for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;

    rst_n = 1'b0; mem_req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    addr = '0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_ready", mem_ready, 0);
    check("reset_err", mem_err, 0);
    check("reset_rdata", ram_data_out, 8'h00);
    check("reset_state", state_dbg, 0);
    rst_n = 1'b1;
    @(negedge clk);

    add_vec(1, 0, 1, 8'h10, 8'h5A, 1, 0, 8'h00);
    add_vec(1, 1, 0, 8'h10, 8'h00, 1, 0, 8'h5A);
    add_vec(1, 0, 1, 8'h22, 8'hC3, 1, 0, 8'h5A);
    add_vec(1, 1, 0, 8'h22, 8'h00, 1, 0, 8'hC3);
    add_vec(1, 1, 1, 8'h10, 8'h77, 0, 1, 8'hC3);
    add_vec(1, 0, 0, 8'h10, 8'h77, 0, 1, 8'hC3);
    add_vec(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'hC3);
    add_vec(1, 1, 0, 8'h10, 8'h00, 1, 0, 8'h5A);
    add_vec(1, 0, 1, 8'h00, 8'h11, 1, 0, 8'h5A);
    add_vec(1, 0, 1, 8'h7F, 8'hE7, 1, 0, 8'h5A);
    add_vec(1, 1, 0, 8'h7F, 8'h00, 1, 0, 8'hE7);
`ifdef DATA_RAM_BOUNDS_CHECK_EN
    add_vec(1, 1, 0, 8'h80, 8'h00, 0, 1, 8'hE7);
    add_vec(1, 0, 1, 8'h90, 8'h99, 0, 1, 8'hE7);
    add_vec(1, 1, 0, 8'h10, 8'h00, 1, 0, 8'h5A);
`else
    add_vec(1, 1, 0, 8'h80, 8'h00, 1, 0, 8'h11);
    add_vec(1, 0, 1, 8'h90, 8'h99, 1, 0, 8'h11);
    add_vec(1, 1, 0, 8'h10, 8'h00, 1, 0, 8'h99);
`endif

    foreach (vecs[i]) begin
      model_eval(vecs[i].req, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, acc, err, rdo);
      run_req($sformatf("vec%0d", i), vecs[i].req, vecs[i].rd, vecs[i].wr, vecs[i].a,
              vecs[i].d, vecs[i].exp_acc, vecs[i].exp_err, vecs[i].exp_rdo, 1'b0);
    end

    // A store presented while a load is in flight must be dropped.
    model_eval(1, 1, 0, 8'h22, 8'h00, acc, err, rdo);
    run_req("busy_ignore", 1, 1, 0, 8'h22, 8'h00, 1, 0, 8'hC3, 1'b1);
    model_eval(1, 1, 0, 8'h22, 8'h00, acc, err, rdo);
    run_req("busy_ignore_reread", 1, 1, 0, 8'h22, 8'h00, 1, 0, 8'hC3, 1'b0);

    // Reset while a store is still waiting: no commit, no completion pulse.
    mem_req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; addr = 8'h22; wr_data = 8'h44;
    @(posedge clk);
    #1;
    mem_req = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", mem_ready, 0);
    check("rst_mid_rdata", ram_data_out, 8'h00);
    check("rst_mid_state", state_dbg, 0);
    rst_n = 1'b1;
    model_rd = 8'h00;
    rdy_n = 0;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      if (mem_ready || busy) rdy_n++;
    end
    check("rst_mid_quiet", rdy_n, 0);
    model_eval(1, 1, 0, 8'h22, 8'h00, acc, err, rdo);
    run_req("rst_mid_reread", 1, 1, 0, 8'h22, 8'h00, acc, err, rdo, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      if (op < 4) begin
        model_eval(1, 0, 1, a, d, acc, err, rdo);
        junk = acc && ($urandom_range(0, 1) == 1);
        run_req($sformatf("rnd%0d_st", n), 1, 0, 1, a, d, acc, err, rdo, junk);
      end else if (op < 8) begin
        if (!model_vld[int'(a) % DEPTH]) begin
          model_eval(1, 0, 1, a, d, acc, err, rdo);
          run_req($sformatf("rnd%0d_st", n), 1, 0, 1, a, d, acc, err, rdo, 1'b0);
        end else begin
          model_eval(1, 1, 0, a, d, acc, err, rdo);
          junk = acc && ($urandom_range(0, 1) == 1);
          run_req($sformatf("rnd%0d_ld", n), 1, 1, 0, a, d, acc, err, rdo, junk);
        end
      end else if (op == 8) begin
        junk = ($urandom_range(0, 1) == 1);
        model_eval(1, junk, junk, a, d, acc, err, rdo);
        run_req($sformatf("rnd%0d_bad", n), 1, junk, junk, a, d, acc, err, rdo, 1'b0);
      end else begin
        model_eval(0, 1, 0, a, d, acc, err, rdo);
        run_req($sformatf("rnd%0d_idle", n), 0, 1, 0, a, d, acc, err, rdo, 1'b0);
      end
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
